// File: rtl/ir_emisor_pulsado.sv
// Pulsed IR emitter scanner: lights one channel at a time, samples each receiver
// dark then lit, and reports only reflections that are absent in ambient light.
module ir_emisor_pulsado #(
  parameter int N_CH         = 5,
  parameter int PHASE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] infras_in,
  output logic [N_CH-1:0] leds,
  output logic [N_CH-1:0] infras_out,
  output logic [N_CH-1:0] ambient_out,
  output logic            valid,
  output logic            busy
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  ONE      = N_CH'(1);

  generate
    if (PHASE_CYCLES < 4) begin : g_bad_phase
      $error("ir_emisor_pulsado: PHASE_CYCLES must be >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DARK, LIT} state_t;

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0] sync_p0, sync_p1;
  logic [N_CH-1:0] amb, lit;
  logic [N_CH-1:0] lit_fresh;

  // Stage p0/p1: two-flop synchronizer for the asynchronous receiver lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= infras_in;
      sync_p1 <= sync_p0;
    end
  end

  // Lit vector with the current channel's bit already replaced by the live sample,
  // so the final channel of a frame is committed on the same edge it is sampled.
  always_comb begin
    lit_fresh     = lit;
    lit_fresh[ch] = sync_p1[ch];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      cnt         <= '0;
      amb         <= '0;
      lit         <= '0;
      leds        <= '0;
      infras_out  <= '0;
      ambient_out <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          leds <= '0;
          if (enable) begin
            state <= DARK;
            ch    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        DARK: begin
          if (cnt == CNT_LAST) begin
            amb[ch] <= sync_p1[ch];
            cnt     <= '0;
            state   <= LIT;
            leds    <= ONE << ch;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LIT: begin
          if (cnt == CNT_LAST) begin
            lit  <= lit_fresh;
            cnt  <= '0;
            leds <= '0;
            if (ch == CH_LAST) begin
              infras_out  <= lit_fresh & ~amb;
              ambient_out <= amb;
              valid       <= 1'b1;
              ch          <= '0;
              if (enable) begin
                state <= DARK;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              ch    <= ch + CH_W'(1);
              state <= DARK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          leds  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ir_emisor_pulsado.md
Name: ir_emisor_pulsado

Overview:
- Drives the robot's five IR emitter LEDs one channel at a time.
- For each channel, samples the matching receiver line twice: once with all LEDs dark (ambient) and once with that channel's LED lit.
- Reports a channel as reflective only when it reads light while lit and dark while unlit. This rejects sunlight and room-lamp interference.
- Sits between the IR LED pins and the sensor-readout path, and feeds ambient-rejected sensor bits to the CPU/line-follow logic.

Parameters:
- N_CH, 5, number of emitter/receiver channel pairs.
- PHASE_CYCLES, 1000, clock cycles per phase (dark or lit), per channel. Legal range is >= 4; a smaller value is a synthesis error.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run frames continuously; 0 = stop at the end of the current frame.
- infras_in  input  N_CH  raw receiver lines, active-high (1 = receiver sees IR light); asynchronous to clk.
- leds  output  N_CH  emitter LED drives, registered, at most one bit high.
- infras_out  output  N_CH  ambient-rejected reflection bits of the last completed frame.
- ambient_out  output  N_CH  ambient (dark-phase) bits of the last completed frame.
- valid  output  1  one-cycle pulse when infras_out/ambient_out update.
- busy  output  1  1 while not in IDLE.

Behaviour:
- Reset (rst_n=0), asynchronous and immediate, independent of clk:
  - leds=0, infras_out=0, ambient_out=0, valid=0, busy=0.
  - Synchronizer and all internal registers cleared.
  - State=IDLE, ch=0, cnt=0.
- Input synchronizer: infras_in passes through 2 flip-flops (sync). All sampling uses sync, so its value reflects infras_in from 2 cycles earlier.
- States: IDLE, DARK, LIT.
  - IDLE: leds=0, busy=0. If enable=1 on a clock edge, go to DARK with ch=0, cnt=0.
  - DARK: leds=0, cnt counts 0..PHASE_CYCLES-1. On the cnt=PHASE_CYCLES-1 cycle, latch amb[ch]=sync[ch], clear cnt, go to LIT.
  - LIT: leds = one-hot(ch), cnt counts 0..PHASE_CYCLES-1. On the cnt=PHASE_CYCLES-1 cycle, latch lit[ch]=sync[ch], clear cnt, then:
    - if ch<N_CH-1: ch=ch+1, go to DARK;
    - if ch=N_CH-1 (end of frame): commit (below), ch=0; go to DARK if enable=1, else IDLE.
- leds is a registered decode of state/ch. It is high exactly during the PHASE_CYCLES cycles of LIT for that channel.
- Commit, on the same edge as the last LIT sample:
  - infras_out[i] = lit[i] AND NOT amb[i], using the freshly latched bit for the last channel.
  - ambient_out = amb.
  - valid=1 for exactly the next cycle.
- Outputs hold their values between commits.
- Frame length = N_CH*2*PHASE_CYCLES cycles. valid pulses repeat with exactly this period while enable stays 1.
- First valid appears 2*N_CH*PHASE_CYCLES+1 cycles after the edge that sampled enable=1 in IDLE.
- Enable handling:
  - enable is sampled only in IDLE and at end of frame.
  - Dropping enable mid-frame does not abort the frame; it completes and commits normally.
- Channel counter wraps N_CH-1 -> 0 only at frame end. Partial frames never commit.
- Sensor stuck at 1 (saturated by ambient): amb=1 gives infras_out=0 for that channel.
- Sensor stuck at 0: lit=0 gives infras_out=0.
- Reset asserted mid-frame: partial amb/lit data is discarded. After rst_n release with enable=1, the block restarts at DARK ch=0.
- No glitches on leds: registered outputs only; no combinational path from any input to any output.

Test Plan (PHASE_CYCLES=8, N_CH=5, frame=80 cycles):
- Reset check: rst_n=0 with random infras_in and enable=1 -> leds, infras_out, ambient_out, valid, busy all 0. Drop rst_n mid-cycle -> outputs clear with no clock edge.
- Basic frame, sensor model with infras_in[i]=leds[i] for i in {0,2}, else 0; enable=1 ->
  - leds shows 8 cycles of 0 then 8 cycles of 00001, repeating per channel through 10000;
  - valid at cycle 81;
  - infras_out=00101, ambient_out=00000.
- Ambient rejection, infras_in=11111 constant -> infras_out=00000, ambient_out=11111. Repeat with infras_in=00000 -> both 00000.
- Enable drop, enable=1 then 0 at cycle 30 ->
  - frame completes;
  - exactly one valid at cycle 81;
  - then IDLE with busy=0, leds=0 held for 200 cycles.
- Continuous run with the model from the basic-frame scenario changed after the first frame to reflect channels {1,4} ->
  - valid pulses 80 cycles apart;
  - first commit 00101, second commit 10010;
  - outputs stable between pulses.
- Mid-frame reset, assert rst_n=0 during LIT of ch=2 ->
  - leds=0 immediately, no valid;
  - after release with enable=1, leds sequence restarts from ch0 and the first valid arrives 81 cycles later with the correct value.
